pipeline_control: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline (fetch, decode, execute, memory, writeback). It drives the per-stage `stall`/`invalidate` pairs that the stage registers consume. It covers load-use interlocks, branch redirects, trap/mret flushes, memory back-pressure and WFI sleep. It also keeps a free-running stall-cycle counter for performance monitoring.

---
 rtl/pipeline_control.sv | 131 +++++++++++++
 tb/tb_pipeline_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Drives per-stage stall/invalidate pairs and counts RUN-state fetch stalls.
module pipeline_control #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_valid,
  input  logic [4:0]  decode_rs1_address,
  input  logic [4:0]  decode_rs2_address,
  input  logic        decode_uses_rs1,
  input  logic        decode_uses_rs2,
  input  logic        execute_valid,
  input  logic        execute_load,
  input  logic [4:0]  execute_rd_address,
  input  logic        execute_branch_taken,
  input  logic        memory_busy,
  input  logic        writeback_trap,
  input  logic        writeback_mret,
  input  logic        writeback_wfi,
  input  logic        interrupt_pending,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        stall_memory,
  output logic        invalidate_fetch,
  output logic        invalidate_decode,
  output logic        invalidate_execute,
  output logic        invalidate_memory,
  output logic        sleeping,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_RUN,
    ST_SLEEP
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Vectors ordered {fetch, decode, execute, memory}
  logic [3:0]  stall_vec;
  logic [3:0]  inv_vec;
  logic        load_use;
  logic        redirect;

  assign redirect = writeback_trap | writeback_mret;

  assign load_use = decode_valid && execute_valid && execute_load &&
                    (execute_rd_address != 5'd0) &&
                    ((decode_uses_rs1 && (decode_rs1_address == execute_rd_address)) ||
                     (decode_uses_rs2 && (decode_rs2_address == execute_rd_address)));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_vec   = 4'b0000;
    inv_vec     = 4'b0000;
    case (state_q)
      ST_FLUSH: begin
        inv_vec = 4'b1111;
        if (redirect) begin
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          inv_vec     = 4'b1111;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = ST_FLUSH;
        end else if (writeback_wfi && !interrupt_pending) begin
          stall_vec = 4'b1111;
          state_d   = ST_SLEEP;
        end else if (memory_busy) begin
          stall_vec = 4'b1111;
        end else if (execute_branch_taken) begin
          inv_vec = 4'b1100;
        end else if (load_use) begin
          // Hold fetch, let decode push one bubble into execute
          stall_vec = 4'b1000;
          inv_vec   = 4'b0100;
        end
      end
      ST_SLEEP: begin
        stall_vec = 4'b1111;
        if (writeback_trap) begin
          flush_cnt_d = FLUSH_LOAD;
          state_d     = ST_FLUSH;
        end else if (interrupt_pending) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        inv_vec     = 4'b1111;
        flush_cnt_d = FLUSH_LOAD;
        state_d     = ST_FLUSH;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q == ST_RUN) && stall_vec[3]) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FLUSH;
      flush_cnt_q    <= FLUSH_LOAD;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign {stall_fetch, stall_decode, stall_execute, stall_memory} = stall_vec;
  assign {invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory} = inv_vec;
  assign sleeping     = (state_q == ST_SLEEP);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control with FLUSH_CYCLES=3.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        decode_valid = 1'b0;
  logic [4:0]  decode_rs1_address = 5'd0;
  logic [4:0]  decode_rs2_address = 5'd0;
  logic        decode_uses_rs1 = 1'b0;
  logic        decode_uses_rs2 = 1'b0;
  logic        execute_valid = 1'b0;
  logic        execute_load = 1'b0;
  logic [4:0]  execute_rd_address = 5'd0;
  logic        execute_branch_taken = 1'b0;
  logic        memory_busy = 1'b0;
  logic        writeback_trap = 1'b0;
  logic        writeback_mret = 1'b0;
  logic        writeback_wfi = 1'b0;
  logic        interrupt_pending = 1'b0;
  logic        stall_fetch, stall_decode, stall_execute, stall_memory;
  logic        invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory;
  logic        sleeping;
  logic [31:0] stall_cycles;

  pipeline_control #(.FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .decode_valid(decode_valid),
    .decode_rs1_address(decode_rs1_address),
    .decode_rs2_address(decode_rs2_address),
    .decode_uses_rs1(decode_uses_rs1),
    .decode_uses_rs2(decode_uses_rs2),
    .execute_valid(execute_valid),
    .execute_load(execute_load),
    .execute_rd_address(execute_rd_address),
    .execute_branch_taken(execute_branch_taken),
    .memory_busy(memory_busy),
    .writeback_trap(writeback_trap),
    .writeback_mret(writeback_mret),
    .writeback_wfi(writeback_wfi),
    .interrupt_pending(interrupt_pending),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .stall_execute(stall_execute), .stall_memory(stall_memory),
    .invalidate_fetch(invalidate_fetch), .invalidate_decode(invalidate_decode),
    .invalidate_execute(invalidate_execute), .invalidate_memory(invalidate_memory),
    .sleeping(sleeping),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Stimulus flag bits
  localparam int DV = 0, U1 = 1, U2 = 2, EV = 3, EL = 4, BR = 5;
  localparam int MB = 6, TR = 7, MR = 8, WF = 9, IP = 10;
  localparam logic [3:0] NONE = 4'b0000, ALL = 4'b1111;

  typedef struct {
    string       tag;
    logic [40:0] vec;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] exp_cnt = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic applyStimulus(input string tag, input logic rst, input logic [10:0] f,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [3:0] es, input logic [3:0] ei, input logic esl,
                               input bit counted);
    sb_entry_t e;
    rst_n                = rst;
    decode_valid         = f[DV];
    decode_uses_rs1      = f[U1];
    decode_uses_rs2      = f[U2];
    execute_valid        = f[EV];
    execute_load         = f[EL];
    execute_branch_taken = f[BR];
    memory_busy          = f[MB];
    writeback_trap       = f[TR];
    writeback_mret       = f[MR];
    writeback_wfi        = f[WF];
    interrupt_pending    = f[IP];
    decode_rs1_address   = rs1;
    decode_rs2_address   = rs2;
    execute_rd_address   = rd;
    if (!rst) exp_cnt = 32'd0;
    e.tag = tag;
    e.vec = {es, ei, esl, exp_cnt};
    sb_q.push_back(e);
    if (counted) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic checkOutput();
    sb_entry_t   e;
    logic [40:0] obs;
    @(negedge clk);
    obs = {stall_fetch, stall_decode, stall_execute, stall_memory,
           invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
           sleeping, stall_cycles};
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed no entry, expected one");
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.vec) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed stall=%b inv=%b sleep=%b cnt=%h, expected stall=%b inv=%b sleep=%b cnt=%h",
               e.tag, obs[40:37], obs[36:33], obs[32], obs[31:0],
               e.vec[40:37], e.vec[36:33], e.vec[32], e.vec[31:0]);
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [10:0] f,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [3:0] es, input logic [3:0] ei, input logic esl,
                      input bit counted);
    @(posedge clk);
    #1;
    applyStimulus(tag, rst, f, rs1, rs2, rd, es, ei, esl, counted);
    checkOutput();
  endtask

  localparam logic [10:0] LU2 = (11'd1 << DV) | (11'd1 << U2) | (11'd1 << EV) | (11'd1 << EL);
  localparam logic [10:0] LU1 = (11'd1 << DV) | (11'd1 << U1) | (11'd1 << EV) | (11'd1 << EL);

  initial begin
    // Reset and three-cycle flush
    step("reset",       1'b0, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("flush1",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("flush2",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("flush3",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("run_idle",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // Load-use hazards
    step("lu_rs2",      1'b1, LU2, 5'd0, 5'd5, 5'd5, 4'b1000, 4'b0100, 1'b0, 1'b1);
    step("lu_after",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);
    step("lu_rd0",      1'b1, LU2, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);
    step("lu_rs1",      1'b1, LU1, 5'd7, 5'd3, 5'd7, 4'b1000, 4'b0100, 1'b0, 1'b1);
    step("lu_unused",   1'b1, LU1, 5'd2, 5'd9, 5'd9, NONE, NONE, 1'b0, 1'b0);

    // Branch held behind memory back-pressure
    step("br_busy1",    1'b1, (11'd1 << BR) | (11'd1 << MB), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    step("br_busy2",    1'b1, (11'd1 << BR) | (11'd1 << MB), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    step("br_free",     1'b1, (11'd1 << BR), 5'd0, 5'd0, 5'd0, NONE, 4'b1100, 1'b0, 1'b0);
    step("br_after",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // WFI with interrupt already pending retires without sleeping
    step("wfi_ip",      1'b1, (11'd1 << WF) | (11'd1 << IP), 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);
    step("wfi_ip_after",1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // WFI sleep and interrupt wake
    step("wfi_enter",   1'b1, (11'd1 << WF), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    step("sleep1",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b1, 1'b0);
    step("sleep2",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b1, 1'b0);
    step("sleep_wake",  1'b1, (11'd1 << IP), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b1, 1'b0);
    step("woken",       1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // Trap beats branch and back-pressure, then three flush cycles
    step("trap_prio",   1'b1, (11'd1 << TR) | (11'd1 << BR) | (11'd1 << MB), 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("trap_fl1",    1'b1, (11'd1 << MB), 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("trap_fl2",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("trap_fl3",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("trap_run",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // Trap with wfi in the same cycle: no sleep; mret in FLUSH reloads
    step("trap_wfi",    1'b1, (11'd1 << TR) | (11'd1 << WF), 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("tw_fl1",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("tw_mret",     1'b1, (11'd1 << MR), 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("tw_fl2",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("tw_fl3",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("tw_fl4",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("tw_run",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // Trap while sleeping takes the flush path
    step("ws_enter",    1'b1, (11'd1 << WF), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    step("ws_trap",     1'b1, (11'd1 << TR), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b1, 1'b0);
    step("ws_fl1",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("ws_fl2",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("ws_fl3",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("ws_run",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // Counter wrap from a preloaded all-ones value
    @(posedge clk);
    #1;
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    exp_cnt = 32'hFFFF_FFFF;
    applyStimulus("wrap_pre", 1'b1, (11'd1 << MB), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    checkOutput();
    step("wrap_zero",   1'b1, (11'd1 << MB), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    step("wrap_one",    1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    // Reset asserted mid-sleep restarts in FLUSH
    step("mr_enter",    1'b1, (11'd1 << WF), 5'd0, 5'd0, 5'd0, ALL, NONE, 1'b0, 1'b1);
    step("mr_reset",    1'b0, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("mr_fl1",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("mr_fl2",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("mr_fl3",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, ALL, 1'b0, 1'b0);
    step("mr_run",      1'b1, 11'd0, 5'd0, 5'd0, 5'd0, NONE, NONE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
